// File: rtl/gin_tag_issuer.sv
// Source end of the GIN tagged-multicast bus. Programs the multicast controller IDs,
// then issues tagged packets and waits for every matching destination to be ready.
module gin_tag_issuer #(
   parameter int ID_SIZE    = 5,
   parameter int DATA_WIDTH = 16,
   parameter int NUM_DEST   = 12
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_start,
   input  logic [NUM_DEST*ID_SIZE-1:0]  cfg_ids,
   output logic                         cfg_busy,
   output logic                         cfg_done,
   output logic [NUM_DEST-1:0]          set_id,
   output logic [ID_SIZE-1:0]           id_out,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ID_SIZE-1:0]           in_tag,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic                         bus_valid,
   output logic [ID_SIZE-1:0]           bus_tag,
   output logic [DATA_WIDTH-1:0]        bus_data,
   input  logic [NUM_DEST-1:0]          dest_ready,
   output logic [15:0]                  xfer_count,
   output logic [15:0]                  drop_count
);

   localparam int IDX_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DEST - 1);

   typedef enum logic [1:0] {RUN, DRAIN, PROG} state_t;

   state_t             state;
   logic [IDX_W-1:0]   prog_idx;
   logic [ID_SIZE-1:0] tbl [NUM_DEST];
   logic [NUM_DEST-1:0] match;
   logic               accept;
   logic               no_match;
   logic               load;

   // A packet completes once every destination holding its tag is ready; no holder means drop.
   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_DEST; i++) match[i] = (tbl[i] == bus_tag);
   end

   assign accept   = bus_valid & (&(dest_ready | ~match));
   assign no_match = ~|match;
   assign in_ready = ~rst & (state == RUN) & ~cfg_start & (~bus_valid | accept);
   assign load     = in_valid & in_ready;
   assign cfg_busy = (state != RUN);

   always_comb begin
      set_id = '0;
      id_out = '0;
      if (state == PROG) begin
         set_id = NUM_DEST'(1) << prog_idx;
         for (int i = 0; i < NUM_DEST; i++)
            if (prog_idx == IDX_W'(i)) id_out = cfg_ids[i*ID_SIZE +: ID_SIZE];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_DEST; i++) tbl[i] <= '0;
      end else if (state == PROG) begin
         for (int i = 0; i < NUM_DEST; i++)
            if (prog_idx == IDX_W'(i)) tbl[i] <= cfg_ids[i*ID_SIZE +: ID_SIZE];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         prog_idx <= '0;
         cfg_done <= 1'b0;
      end else begin
         cfg_done <= 1'b0;
         case (state)
            RUN: if (cfg_start) begin
               prog_idx <= '0;
               state    <= (bus_valid & ~accept) ? DRAIN : PROG;
            end
            DRAIN: if (accept) state <= PROG;
            PROG: begin
               if (prog_idx == LAST_IDX) begin
                  state    <= RUN;
                  cfg_done <= 1'b1;
               end else begin
                  prog_idx <= prog_idx + 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_valid <= 1'b0;
         bus_tag   <= '0;
         bus_data  <= '0;
      end else if (load) begin
         bus_valid <= 1'b1;
         bus_tag   <= in_tag;
         bus_data  <= in_data;
      end else if (accept) begin
         bus_valid <= 1'b0;
      end
   end

   // Only RUN-state completions are counted; the packet drained before programming is not.
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_count <= '0;
         drop_count <= '0;
      end else if (state == RUN && accept) begin
         if (no_match) begin
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end else begin
            xfer_count <= xfer_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_gin_tag_issuer.sv
// Directed bench for gin_tag_issuer: programming, issue/stall, drops, drain and reset abort.
module tb_gin_tag_issuer;

   localparam int ID_SIZE = 5;
   localparam int DATA_WIDTH = 16;
   localparam int NUM_DEST = 12;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        cfg_start;
   logic [NUM_DEST*ID_SIZE-1:0] cfg_ids;
   logic                        cfg_busy, cfg_done;
   logic [NUM_DEST-1:0]         set_id;
   logic [ID_SIZE-1:0]          id_out;
   logic                        in_valid, in_ready;
   logic [ID_SIZE-1:0]          in_tag;
   logic [DATA_WIDTH-1:0]       in_data;
   logic                        bus_valid;
   logic [ID_SIZE-1:0]          bus_tag;
   logic [DATA_WIDTH-1:0]       bus_data;
   logic [NUM_DEST-1:0]         dest_ready;
   logic [15:0]                 xfer_count, drop_count;

   int checks = 0;
   int errors = 0;

   gin_tag_issuer #(.ID_SIZE(ID_SIZE), .DATA_WIDTH(DATA_WIDTH), .NUM_DEST(NUM_DEST)) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_ids(cfg_ids),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .set_id(set_id), .id_out(id_out),
      .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
      .bus_valid(bus_valid), .bus_tag(bus_tag), .bus_data(bus_data),
      .dest_ready(dest_ready), .xfer_count(xfer_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs settle 1-2 time units after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_all_ids(input logic [ID_SIZE-1:0] v);
      for (int i = 0; i < NUM_DEST; i++) cfg_ids[i*ID_SIZE +: ID_SIZE] = v;
   endtask

   task automatic program_table();
      cfg_start = 1'b1;
      cyc();
      cfg_start = 1'b0;
      repeat (NUM_DEST) cyc();
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_start = 0; cfg_ids = '0; in_valid = 0; in_tag = '0; in_data = '0;
      dest_ready = '0;
      repeat (3) cyc();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
      rst = 1'b0;
      cyc();
      checks++; if (bus_valid !== 1'b0 || cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin errors++;
         $display("[TB] FAIL reset_flags: valid %b busy %b done %b want 000", bus_valid, cfg_busy, cfg_done); end
      checks++; if (xfer_count !== 16'd0 || drop_count !== 16'd0) begin errors++;
         $display("[TB] FAIL reset_counts: xfer %h drop %h want 0 0", xfer_count, drop_count); end
      checks++; if (set_id !== '0 || id_out !== '0) begin errors++;
         $display("[TB] FAIL reset_setid: set_id %h id_out %h want 0 0", set_id, id_out); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_after: got %b want 1", in_ready); end
   endtask

   task automatic test_program();
      for (int i = 0; i < NUM_DEST; i++) cfg_ids[i*ID_SIZE +: ID_SIZE] = ID_SIZE'(i);
      cfg_start = 1'b1;
      settle();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL prog_ready_on_start: got %b want 0", in_ready); end
      cyc();
      cfg_start = 1'b0;
      for (int k = 0; k < NUM_DEST; k++) begin
         checks++; if (set_id !== NUM_DEST'(1 << k) || id_out !== ID_SIZE'(k) || cfg_busy !== 1'b1 || cfg_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prog_step%0d: set_id %h id %0d busy %b done %b want %h %0d 1 0",
                     k, set_id, id_out, cfg_busy, cfg_done, 1 << k, k);
         end
         cyc();
      end
      checks++; if (cfg_done !== 1'b1 || cfg_busy !== 1'b0 || set_id !== '0) begin errors++;
         $display("[TB] FAIL prog_done: done %b busy %b set_id %h want 1 0 0", cfg_done, cfg_busy, set_id); end
      cyc();
      checks++; if (cfg_done !== 1'b0) begin errors++; $display("[TB] FAIL prog_done_pulse: got %b want 0", cfg_done); end
   endtask

   task automatic test_issue();
      in_valid = 1; in_tag = 5'd3; in_data = 16'hBEEF; dest_ready = 12'h008;
      cyc();
      in_valid = 0;
      checks++; if (bus_valid !== 1'b1 || bus_tag !== 5'd3 || bus_data !== 16'hBEEF) begin errors++;
         $display("[TB] FAIL issue_bus: valid %b tag %0d data %h want 1 3 beef", bus_valid, bus_tag, bus_data); end
      cyc();
      checks++; if (bus_valid !== 1'b0 || xfer_count !== 16'd1) begin errors++;
         $display("[TB] FAIL issue_accept: valid %b xfer %0d want 0 1", bus_valid, xfer_count); end
      dest_ready = 12'h000; in_valid = 1; in_tag = 5'd3; in_data = 16'h1234;
      cyc();
      in_valid = 0; in_data = 16'hDEAD;
      repeat (3) begin
         cyc();
         checks++; if (bus_valid !== 1'b1 || bus_data !== 16'h1234 || bus_tag !== 5'd3 || in_ready !== 1'b0) begin errors++;
            $display("[TB] FAIL issue_stall: valid %b tag %0d data %h ready %b want 1 3 1234 0", bus_valid, bus_tag, bus_data, in_ready); end
      end
      dest_ready = 12'hFF7;
      cyc();
      checks++; if (bus_valid !== 1'b1) begin errors++; $display("[TB] FAIL issue_other_ready: valid %b want 1", bus_valid); end
      dest_ready = 12'h008;
      cyc();
      checks++; if (bus_valid !== 1'b0 || xfer_count !== 16'd2) begin errors++;
         $display("[TB] FAIL issue_release: valid %b xfer %0d want 0 2", bus_valid, xfer_count); end
   endtask

   task automatic test_multicast();
      set_all_ids(5'd7);
      program_table();
      dest_ready = '0; in_valid = 1; in_tag = 5'd7; in_data = 16'h0707;
      cyc();
      in_valid = 0;
      for (int i = 0; i < NUM_DEST - 1; i++) begin
         dest_ready = NUM_DEST'((1 << (i + 1)) - 1);
         cyc();
         checks++; if (bus_valid !== 1'b1 || xfer_count !== 16'd2) begin errors++;
            $display("[TB] FAIL mc_partial%0d: valid %b xfer %0d want 1 2", i, bus_valid, xfer_count); end
      end
      dest_ready = 12'hFFF;
      cyc();
      checks++; if (bus_valid !== 1'b0 || xfer_count !== 16'd3) begin errors++;
         $display("[TB] FAIL mc_full: valid %b xfer %0d want 0 3", bus_valid, xfer_count); end
      for (int p = 0; p < 4; p++) begin
         in_valid = 1; in_data = 16'hA000 + 16'(p);
         settle();
         checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready%0d: got %b want 1", p, in_ready); end
         cyc();
         checks++; if (bus_valid !== 1'b1 || bus_data !== 16'hA000 + 16'(p)) begin errors++;
            $display("[TB] FAIL b2b_data%0d: valid %b data %h want 1 %h", p, bus_valid, bus_data, 16'hA000 + 16'(p)); end
      end
      in_valid = 0;
      cyc();
      checks++; if (bus_valid !== 1'b0 || xfer_count !== 16'd7) begin errors++;
         $display("[TB] FAIL b2b_count: valid %b xfer %0d want 0 7", bus_valid, xfer_count); end
   endtask

   task automatic test_drop();
      dest_ready = '0; in_valid = 1; in_tag = 5'd20; in_data = 16'h5555;
      cyc();
      in_valid = 0;
      checks++; if (bus_valid !== 1'b1 || in_ready !== 1'b1) begin errors++;
         $display("[TB] FAIL drop_bus: valid %b ready %b want 1 1", bus_valid, in_ready); end
      cyc();
      checks++; if (bus_valid !== 1'b0 || drop_count !== 16'd1 || xfer_count !== 16'd7) begin errors++;
         $display("[TB] FAIL drop_one: valid %b drop %0d xfer %0d want 0 1 7", bus_valid, drop_count, xfer_count); end
      in_valid = 1;
      repeat (65536) cyc();
      in_valid = 0;
      cyc();
      checks++; if (drop_count !== 16'hFFFF || xfer_count !== 16'd7) begin errors++;
         $display("[TB] FAIL drop_sat: drop %h xfer %0d want ffff 7", drop_count, xfer_count); end
   endtask

   task automatic test_drain_abort();
      set_all_ids(5'd9);
      dest_ready = '0; in_valid = 1; in_tag = 5'd7; in_data = 16'hCAFE;
      cyc();
      in_valid = 0; cfg_start = 1;
      settle();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL drain_start_ready: got %b want 0", in_ready); end
      cyc();
      cfg_start = 0;
      repeat (2) begin
         checks++; if (cfg_busy !== 1'b1 || in_ready !== 1'b0 || set_id !== '0 || bus_valid !== 1'b1) begin errors++;
            $display("[TB] FAIL drain_hold: busy %b ready %b set_id %h valid %b want 1 0 0 1", cfg_busy, in_ready, set_id, bus_valid); end
         cyc();
      end
      dest_ready = 12'hFFF;
      cyc();
      checks++; if (bus_valid !== 1'b0 || set_id !== 12'h001 || id_out !== 5'd9 || xfer_count !== 16'd7) begin errors++;
         $display("[TB] FAIL drain_to_prog: valid %b set_id %h id %0d xfer %0d want 0 001 9 7", bus_valid, set_id, id_out, xfer_count); end
      repeat (4) cyc();
      checks++; if (set_id !== 12'h010) begin errors++; $display("[TB] FAIL prog_fifth: set_id %h want 010", set_id); end
      rst = 1;
      cyc();
      rst = 0;
      checks++; if (cfg_busy !== 1'b0 || cfg_done !== 1'b0 || set_id !== '0 || drop_count !== 16'd0) begin errors++;
         $display("[TB] FAIL abort_state: busy %b done %b set_id %h drop %h want 0 0 0 0", cfg_busy, cfg_done, set_id, drop_count); end
      repeat (NUM_DEST) begin
         cyc();
         checks++; if (cfg_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_done: got %b want 0", cfg_done); end
      end
      dest_ready = '0; in_valid = 1; in_tag = 5'd9;
      cyc();
      in_valid = 0;
      cyc();
      checks++; if (bus_valid !== 1'b0 || drop_count !== 16'd1) begin errors++;
         $display("[TB] FAIL abort_tag9_drop: valid %b drop %0d want 0 1", bus_valid, drop_count); end
      in_valid = 1; in_tag = 5'd0;
      cyc();
      in_valid = 0;
      cyc();
      checks++; if (bus_valid !== 1'b1) begin errors++; $display("[TB] FAIL abort_tag0_stall: valid %b want 1", bus_valid); end
      dest_ready = 12'hFFF;
      cyc();
      checks++; if (bus_valid !== 1'b0 || xfer_count !== 16'd1) begin errors++;
         $display("[TB] FAIL abort_tag0_xfer: valid %b xfer %0d want 0 1", bus_valid, xfer_count); end
   endtask

   initial begin
      test_reset();
      test_program();
      test_issue();
      test_multicast();
      test_drop();
      test_drain_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
